// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - VGA scan timing with word-packed grayscale image fetch; optional TEST_PATTERN_EN
module vga_frame_reader #(
  parameter int CLK_DIV   = 2,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int IMG_X0    = 80,
  parameter int IMG_W     = 480,
  parameter int IMG_H     = 480,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
`ifdef TEST_PATTERN_EN
  input  logic              pattern_sel,
`endif
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [9:0]        x,
  output logic [9:0]        y,
  output logic              active,
  output logic              in_image,
  output logic [7:0]        pixel,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]        H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]        V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]        H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]        V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]        HS_LO    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]        HS_HI    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]        VS_LO    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]        VS_HI    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]        IMG_X_LO = 10'(IMG_X0);
  localparam logic [9:0]        IMG_X_HI = 10'(IMG_X0 + IMG_W);
  localparam logic [9:0]        IMG_Y_HI = 10'(IMG_H);
  localparam logic [1:0]        X0_LO    = IMG_X_LO[1:0];
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [9:0]        hc_q, hc_d, vc_q, vc_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, mem_addr_q, mem_addr_d;
  logic              mem_rd_en_q, mem_rd_en_d, rd_valid_q, rd_valid_d;
  logic [31:0]       word_q, word_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic              active_q, active_d, in_image_q, in_image_d;
  logic [7:0]        pixel_q, pixel_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;
  logic              frame_start_q, frame_start_d;
  logic              pattern_q, pattern_d;

  logic              tick, h_wrap, v_wrap, frame_wrap, fetch, in_img_now;
  logic [ADDR_W-1:0] fetch_addr;
  logic [1:0]        col_next, col_now;
  logic [7:0]        mem_byte;

  function automatic logic in_window(input logic [9:0] h, input logic [9:0] v);
    return (h >= IMG_X_LO) && (h < IMG_X_HI) && (v < IMG_Y_HI);
  endfunction

  // Pattern mode only changes at the frame boundary so a frame is never mixed.
`ifdef TEST_PATTERN_EN
  assign pattern_d = frame_start_d ? pattern_sel : pattern_q;
`else
  assign pattern_d = 1'b0;
`endif

  // Next-state: pixel divider, scan counters, prefetch, capture and output stage.
  always_comb begin
    tick       = (div_q == DIV_LAST);
    div_d      = tick ? '0 : div_q + 1'b1;
    h_wrap     = (hc_q == H_LAST);
    v_wrap     = (vc_q == V_LAST);
    frame_wrap = tick && h_wrap && v_wrap;

    hc_d = hc_q;
    vc_d = vc_q;
    if (tick) begin
      hc_d = h_wrap ? '0 : hc_q + 10'd1;
      if (h_wrap) begin
        vc_d = v_wrap ? '0 : vc_q + 10'd1;
      end
    end

    // A word is fetched as the counters step onto the first column of each
    // 4-pixel group, so it has landed before that group is presented.
    col_next    = hc_d[1:0] - X0_LO;
    fetch       = tick && !pattern_q && in_window(hc_d, vc_d) && (col_next == 2'd0);
    fetch_addr  = frame_wrap ? BASE : rd_ptr_q;
    rd_ptr_d    = fetch_addr;
    if (fetch) begin
      rd_ptr_d = fetch_addr + 1'b1;
    end
    mem_rd_en_d = fetch;
    mem_addr_d  = fetch ? fetch_addr : mem_addr_q;

    // Bypass the word register so the returning word is usable on the same
    // edge it is captured (needed when CLK_DIV is 2).
    rd_valid_d = mem_rd_en_q;
    word_d     = rd_valid_q ? mem_rdata : word_q;

    col_now    = hc_q[1:0] - X0_LO;
    in_img_now = in_window(hc_q, vc_q);
    mem_byte   = word_d[7:0];
    case (col_now)
      2'd0: mem_byte = word_d[7:0];
      2'd1: mem_byte = word_d[15:8];
      2'd2: mem_byte = word_d[23:16];
      2'd3: mem_byte = word_d[31:24];
      default: mem_byte = word_d[7:0];
    endcase

    x_d           = x_q;
    y_d           = y_q;
    active_d      = active_q;
    in_image_d    = in_image_q;
    pixel_d       = pixel_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = 1'b0;
    if (tick) begin
      x_d           = hc_q;
      y_d           = vc_q;
      active_d      = (hc_q < H_ACT) && (vc_q < V_ACT);
      in_image_d    = in_img_now;
      hsync_d       = !((hc_q >= HS_LO) && (hc_q < HS_HI));
      vsync_d       = !((vc_q >= VS_LO) && (vc_q < VS_HI));
      frame_start_d = (hc_q == 10'd0) && (vc_q == 10'd0);
      if (!in_img_now) begin
        pixel_d = '0;
      end else if (pattern_q) begin
        pixel_d = hc_q[7:0] ^ vc_q[7:0];
      end else begin
        pixel_d = mem_byte;
      end
    end
  end

  // State registers; reset drops any read in flight along with its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      hc_q          <= '0;
      vc_q          <= '0;
      rd_ptr_q      <= BASE;
      mem_addr_q    <= BASE;
      mem_rd_en_q   <= 1'b0;
      rd_valid_q    <= 1'b0;
      word_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b0;
      in_image_q    <= 1'b0;
      pixel_q       <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
      pattern_q     <= 1'b0;
    end else begin
      div_q         <= div_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_en_q   <= mem_rd_en_d;
      rd_valid_q    <= rd_valid_d;
      word_q        <= word_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      in_image_q    <= in_image_d;
      pixel_q       <= pixel_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      pattern_q     <= pattern_d;
    end
  end

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_addr    = mem_addr_q;
  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign in_image    = in_image_q;
  assign pixel       = pixel_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule
